mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage: dual-slot BRAM access, writeback registers and the subcore Fetch handshake FSM.
// Optional build macro MEM_FETCH_TIMEOUT_EN adds a REQ-state timeout with a sticky fetch_timeout flag.
module mem_stage #(
    parameter int SUBCORE_NUM   = 4,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        interlock,
    input  logic [31:0] pc_from_exec,
    input  logic [63:0] inst_from_exec,
    input  logic [31:0] u_addr_from_exec,
    input  logic [31:0] l_addr_from_exec,
    input  logic [31:0] u_sdata_from_exec,
    input  logic [31:0] l_sdata_from_exec,
    input  logic [4:0]  u_rt_from_exec,
    input  logic [4:0]  l_rt_from_exec,
    input  logic [3:0]  fetch_core_from_exec,
    output logic [31:0] mem_addra,
    output logic [31:0] mem_addrb,
    output logic [31:0] mem_dina,
    output logic [31:0] mem_dinb,
    output logic        mem_wea,
    output logic        mem_web,
    output logic        fetch_req,
    output logic [3:0]  fetch_core,
    input  logic        fetch_ack,
    output logic        fetch_stall,
    output logic [31:0] pc_to_wb,
    output logic [63:0] inst_to_wb,
    output logic [3:0]  fetch_core_to_wb,
    output logic [4:0]  u_rt_to_wb,
    output logic [4:0]  l_rt_to_wb,
    output logic        fetch_timeout
);

    localparam logic [5:0]  OP_STORE   = 6'h2b;
    localparam logic [5:0]  OP_FETCH   = 6'h3e;
    localparam logic [31:0] CORE_LIMIT = 32'(SUBCORE_NUM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        u_store_s;
    logic        l_store_s;
    logic        u_fetch_s;
    logic        l_fetch_s;
    logic        core_ok_s;
    logic        advance_s;
    logic        timeout_hit_s;
    logic [63:0] inst_wb_s;

    assign u_store_s = (inst_from_exec[63:58] == OP_STORE);
    assign l_store_s = (inst_from_exec[31:26] == OP_STORE);
    assign u_fetch_s = (inst_from_exec[63:58] == OP_FETCH);
    assign l_fetch_s = (inst_from_exec[31:26] == OP_FETCH);
    assign core_ok_s = ({28'd0, fetch_core_from_exec} < CORE_LIMIT);

    // An out-of-range Fetch never handshakes, so it must not stall the pipe either.
    assign fetch_stall = u_fetch_s && core_ok_s && (state_r != ST_DONE);
    assign advance_s   = !interlock && !fetch_stall;

    assign mem_addra = u_addr_from_exec;
    assign mem_addrb = l_addr_from_exec;
    assign mem_dina  = u_sdata_from_exec;
    assign mem_dinb  = l_sdata_from_exec;
    assign mem_wea   = rstn && u_store_s && advance_s;
    // Same-address dual store: the upper slot wins, lower write is dropped.
    assign mem_web   = rstn && l_store_s && advance_s &&
                       !(u_store_s && (u_addr_from_exec == l_addr_from_exec));

    assign fetch_req = (state_r == ST_REQ);

    // Instruction word forwarded to writeback with invalid Fetch slots squashed.
    always_comb begin
        inst_wb_s = inst_from_exec;
        if (u_fetch_s && !core_ok_s) begin
            inst_wb_s[63:32] = 32'd0;
        end else begin
            inst_wb_s[63:32] = inst_from_exec[63:32];
        end
        if (l_fetch_s) begin
            inst_wb_s[31:0] = 32'd0;
        end else begin
            inst_wb_s[31:0] = inst_from_exec[31:0];
        end
    end

    // Writeback-stage pipeline registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_to_wb         <= 32'd0;
            inst_to_wb       <= 64'd0;
            fetch_core_to_wb <= 4'd0;
            u_rt_to_wb       <= 5'd0;
            l_rt_to_wb       <= 5'd0;
        end else if (advance_s) begin
            pc_to_wb         <= pc_from_exec;
            inst_to_wb       <= inst_wb_s;
            fetch_core_to_wb <= fetch_core_from_exec;
            u_rt_to_wb       <= u_rt_from_exec;
            l_rt_to_wb       <= l_rt_from_exec;
        end
    end

    // Fetch FSM next-state logic; only DONE is gated by interlock.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (u_fetch_s && core_ok_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (fetch_ack || timeout_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_DONE: begin
                if (!interlock) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register and captured subcore index for the request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            fetch_core <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_REQ)) begin
                fetch_core <= fetch_core_from_exec;
            end
        end
    end

`ifdef MEM_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(FETCH_TIMEOUT + 1);

    logic [TW-1:0] to_cnt_r;
    logic          timeout_r;

    assign timeout_hit_s = (state_r == ST_REQ) && (to_cnt_r == TW'(FETCH_TIMEOUT - 1));
    assign fetch_timeout = timeout_r;

    // REQ-cycle counter and sticky timeout flag; an ack in the final cycle is not a timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_r  <= '0;
            timeout_r <= 1'b0;
        end else begin
            if ((state_r == ST_REQ) && (state_nxt_s == ST_REQ)) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end else begin
                to_cnt_r <= '0;
            end
            if (timeout_hit_s && !fetch_ack) begin
                timeout_r <= 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = 32'(FETCH_TIMEOUT);
    assign timeout_hit_s    = 1'b0;
    assign fetch_timeout    = 1'b0;
`endif

endmodule
